// File: rtl/regfile_wsel_scoreboard.sv
// Register-file write-select decoder with a per-register pending-write scoreboard.
// Flags RAW hazards on two read ports and WAW on issue; same-cycle writeback resolves RAW.
module regfile_wsel_scoreboard #(
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ctrl_writeEnable,
    input  logic [ADDR_W-1:0]        ctrl_writeReg,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_reg,
    input  logic [ADDR_W-1:0]        ctrl_readRegA,
    input  logic [ADDR_W-1:0]        ctrl_readRegB,
    output logic [(1<<ADDR_W)-1:0]   wsel,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic                     hazard_A,
    output logic                     hazard_B,
    output logic                     waw,
    output logic [ADDR_W:0]          pending_cnt
);

    localparam int unsigned NREG = 1 << ADDR_W;

    typedef logic [ADDR_W:0] cnt_t;

    logic [NREG-1:0] wsel_d, wsel_q;
    logic [NREG-1:0] busy_d, busy_q;
    cnt_t            cnt_d, cnt_q;

    logic wb_is_zero, issue_is_zero, ra_is_zero, rb_is_zero;
    logic wb_hits_a, wb_hits_b, wb_hits_issue;

    always_comb begin
        wb_is_zero    = ZERO_REG && (ctrl_writeReg == '0);
        issue_is_zero = ZERO_REG && (issue_reg == '0);
        ra_is_zero    = ZERO_REG && (ctrl_readRegA == '0);
        rb_is_zero    = ZERO_REG && (ctrl_readRegB == '0);
        wb_hits_a     = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA);
        wb_hits_b     = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB);
        wb_hits_issue = ctrl_writeEnable && (ctrl_writeReg == issue_reg);
    end

    always_comb begin
        wsel_d = '0;
        busy_d = busy_q;
        if (ctrl_writeEnable && !wb_is_zero) begin
            wsel_d[ctrl_writeReg] = 1'b1;
            busy_d[ctrl_writeReg] = 1'b0;
        end
        // Issue is applied after the clear so a same-register issue keeps the bit set.
        if (issue_valid && !issue_is_zero) begin
            busy_d[issue_reg] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + cnt_t'(busy_d[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wsel_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            wsel_q <= wsel_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        hazard_A = busy_q[ctrl_readRegA] && !wb_hits_a && !ra_is_zero;
        hazard_B = busy_q[ctrl_readRegB] && !wb_hits_b && !rb_is_zero;
        waw      = issue_valid && busy_q[issue_reg] && !wb_hits_issue && !issue_is_zero;
    end

    assign wsel        = wsel_q;
    assign busy        = busy_q;
    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wsel_scoreboard.sv
// Scoreboard bench: driver queues each cycle's vector with expected outputs, a monitor checks
// combinational flags before the edge and registered outputs just after it.
module tb_regfile_wsel_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_writeEnable = 1'b0;
    logic [4:0]  ctrl_writeReg = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_reg = '0;
    logic [4:0]  ctrl_readRegA = '0;
    logic [4:0]  ctrl_readRegB = '0;
    logic [31:0] wsel;
    logic [31:0] busy;
    logic        hazard_A;
    logic        hazard_B;
    logic        waw;
    logic [5:0]  pending_cnt;

    regfile_wsel_scoreboard #(
        .ADDR_W   (5),
        .ZERO_REG (1'b1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .issue_valid      (issue_valid),
        .issue_reg        (issue_reg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .wsel             (wsel),
        .busy             (busy),
        .hazard_A         (hazard_A),
        .hazard_B         (hazard_B),
        .waw              (waw),
        .pending_cnt      (pending_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic        rst;
        logic        we;
        logic [4:0]  wr;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ha;
        logic        hb;
        logic        waw;
        logic [31:0] wsel;
        logic [31:0] busy;
        logic [5:0]  cnt;
    } vec_t;

    vec_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_id  = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
        end
    endtask

    // Expected register values describe the state after this vector's clock edge.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                         input logic iv, input logic [4:0] ir, input logic [4:0] ra,
                         input logic [4:0] rb, input logic ha, input logic hb,
                         input logic ew, input logic [31:0] ewsel, input logic [31:0] ebusy,
                         input logic [5:0] ecnt);
        vec_t v;
        @(negedge clock);
        reset = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg = wr;
        issue_valid = iv;
        issue_reg = ir;
        ctrl_readRegA = ra;
        ctrl_readRegB = rb;
        v.id = n_id; v.rst = rst; v.we = we; v.wr = wr; v.iv = iv; v.ir = ir;
        v.ra = ra; v.rb = rb; v.ha = ha; v.hb = hb; v.waw = ew;
        v.wsel = ewsel; v.busy = ebusy; v.cnt = ecnt;
        n_id++;
        q.push_back(v);
    endtask

    initial begin : monitor
        vec_t v;
        forever begin
            @(negedge clock);
            #4;
            if (q.size() != 0) begin
                v = q[0];
                chk("hazard_A", v.id, 32'(hazard_A), 32'(v.ha));
                chk("hazard_B", v.id, 32'(hazard_B), 32'(v.hb));
                chk("waw", v.id, 32'(waw), 32'(v.waw));
                // Reset must clear state between edges, not at the next edge.
                if (v.rst) begin
                    chk("async_wsel", v.id, wsel, 32'h0);
                    chk("async_busy", v.id, busy, 32'h0);
                    chk("async_cnt", v.id, 32'(pending_cnt), 32'h0);
                end
                @(posedge clock);
                #1;
                chk("wsel", v.id, wsel, v.wsel);
                chk("busy", v.id, busy, v.busy);
                chk("pending_cnt", v.id, 32'(pending_cnt), 32'(v.cnt));
                void'(q.pop_front());
            end
        end
    end

    initial begin : driver
        logic [31:0] b;
        bit          drained;
        // Reset held from time zero; issue and writeback are ignored.
        drive(1, 1, 5'd6, 1, 5'd5, 5'd0, 5'd0, 0, 0, 0, 32'h0, 32'h0, 6'd0);

        // Decode sweep, register 0 never selected.
        for (int k = 0; k < 32; k++) begin
            drive(0, 1, 5'(k), 0, 5'd0, 5'd0, 5'd0, 0, 0, 0,
                  (k == 0) ? 32'h0 : (32'h1 << k), 32'h0, 6'd0);
        end

        // RAW on reg 7, resolved by same-cycle writeback.
        drive(0, 0, 5'd0, 1, 5'd7, 5'd0, 5'd0, 0, 0, 0, 32'h0, 32'h80, 6'd1);
        drive(0, 0, 5'd0, 0, 5'd0, 5'd7, 5'd0, 1, 0, 0, 32'h0, 32'h80, 6'd1);
        drive(0, 1, 5'd7, 0, 5'd0, 5'd7, 5'd0, 0, 0, 0, 32'h80, 32'h0, 6'd0);

        // Simultaneous issue and writeback to reg 12 while busy.
        drive(0, 0, 5'd0, 1, 5'd12, 5'd0, 5'd0, 0, 0, 0, 32'h0, 32'h1000, 6'd1);
        drive(0, 1, 5'd12, 1, 5'd12, 5'd0, 5'd12, 0, 0, 0, 32'h1000, 32'h1000, 6'd1);

        // WAW on reg 3.
        b = 32'h1000 | 32'h8;
        drive(0, 0, 5'd0, 1, 5'd3, 5'd0, 5'd0, 0, 0, 0, 32'h0, b, 6'd2);
        drive(0, 0, 5'd0, 1, 5'd3, 5'd0, 5'd3, 0, 1, 1, 32'h0, b, 6'd2);

        // Issue 9 and writeback 3 on the same edge; read 12 still hazards.
        b = 32'h1000 | 32'h200;
        drive(0, 1, 5'd3, 1, 5'd9, 5'd12, 5'd0, 1, 0, 0, 32'h8, b, 6'd2);

        // Writeback to an idle register still drives wsel.
        drive(0, 1, 5'd20, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0010_0000, b, 6'd2);

        // Fill 1, 2, 31 then assert reset between edges.
        b = b | 32'h2;
        drive(0, 0, 5'd0, 1, 5'd1, 5'd0, 5'd0, 0, 0, 0, 32'h0, b, 6'd3);
        b = b | 32'h4;
        drive(0, 0, 5'd0, 1, 5'd2, 5'd0, 5'd0, 0, 0, 0, 32'h0, b, 6'd4);
        b = b | 32'h8000_0000;
        drive(0, 1, 5'd20, 1, 5'd31, 5'd9, 5'd0, 1, 0, 0, 32'h0010_0000, b, 6'd5);
        drive(1, 1, 5'd6, 1, 5'd4, 5'd9, 5'd12, 0, 0, 0, 32'h0, 32'h0, 6'd0);

        // First edge after reset release works normally.
        drive(0, 0, 5'd0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 32'h0, 32'h20, 6'd1);
        drive(0, 1, 5'd5, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h20, 32'h0, 6'd0);

        // Register zero: issue, writeback and read of reg 0 have no effect.
        drive(0, 1, 5'd0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0, 32'h0, 6'd0);
        drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0, 32'h0, 6'd0);

        drained = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!drained) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
